bp_cfg_loader: RTL and testbench

BP_CFG_LOADER -- requirements
Module: bp_cfg_loader

---
 rtl/bp_cfg_loader.sv | 163 ++++++++++++++++
 tb/tb_bp_cfg_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_loader.sv
// Boot-time configuration loader: freezes each core, writes its core id and CCE microcode
// from a synchronous ROM, then unfreezes every core and raises done_o.
module bp_cfg_loader #(
  parameter int unsigned num_core_p              = 1,
  parameter int unsigned num_cce_instr_ram_els_p = 256,
  parameter int unsigned cfg_core_width_p        = 8,
  parameter int unsigned cfg_addr_width_p        = 16,
  parameter int unsigned cfg_data_width_p        = 32,
  localparam int unsigned rom_addr_width_lp =
    (num_cce_instr_ram_els_p > 1) ? $clog2(num_cce_instr_ram_els_p) : 1,
  localparam int unsigned core_cnt_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  output logic [rom_addr_width_lp-1:0] rom_addr_o,
  input  logic [cfg_data_width_p-1:0]  rom_data_i,
  output logic                         cfg_v_o,
  output logic [cfg_core_width_p-1:0]  cfg_core_o,
  output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
  output logic [cfg_data_width_p-1:0]  cfg_data_o,
  input  logic                         cfg_ready_i,
  output logic                         done_o
);

  typedef enum logic [2:0] {
    e_reset,
    e_freeze,
    e_core_id,
    e_rom_rd,
    e_ucode,
    e_unfreeze,
    e_done
  } state_e;

  state_e                         state_q, state_d;
  logic [core_cnt_width_lp-1:0]   core_cnt_q, core_cnt_d;
  logic [rom_addr_width_lp-1:0]   instr_cnt_q, instr_cnt_d;
  logic [cfg_data_width_p-1:0]    word_q, word_d;
  logic                           ucode_first_q, ucode_first_d;

  logic hs;
  logic instr_last;
  logic core_last;

  assign hs         = cfg_v_o & cfg_ready_i;
  assign instr_last = (instr_cnt_q == rom_addr_width_lp'(num_cce_instr_ram_els_p - 1));
  assign core_last  = (core_cnt_q == core_cnt_width_lp'(num_core_p - 1));

  // Outputs decode only registered state, so cfg_v_o never follows cfg_ready_i.
  always_comb begin
    cfg_v_o    = 1'b0;
    cfg_core_o = '0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    rom_addr_o = '0;
    done_o     = 1'b0;
    unique case (state_q)
      e_freeze: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = cfg_core_width_p'(core_cnt_q);
        cfg_addr_o = cfg_addr_width_p'(16'h0000);
        cfg_data_o = cfg_data_width_p'(1);
      end
      e_core_id: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = cfg_core_width_p'(core_cnt_q);
        cfg_addr_o = cfg_addr_width_p'(16'h0001);
        cfg_data_o = cfg_data_width_p'(core_cnt_q);
      end
      e_rom_rd: begin
        rom_addr_o = instr_cnt_q;
      end
      e_ucode: begin
        cfg_v_o    = 1'b1;
        rom_addr_o = instr_cnt_q;
        cfg_core_o = cfg_core_width_p'(core_cnt_q);
        cfg_addr_o = cfg_addr_width_p'(16'h8000) | cfg_addr_width_p'(instr_cnt_q);
        // The ROM word arrives on the entry cycle; after that the captured copy is used.
        cfg_data_o = ucode_first_q ? rom_data_i : word_q;
      end
      e_unfreeze: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = cfg_core_width_p'(core_cnt_q);
        cfg_addr_o = cfg_addr_width_p'(16'h0000);
        cfg_data_o = '0;
      end
      e_done: begin
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    core_cnt_d    = core_cnt_q;
    instr_cnt_d   = instr_cnt_q;
    word_d        = ucode_first_q ? rom_data_i : word_q;
    ucode_first_d = (state_q == e_rom_rd);
    unique case (state_q)
      e_reset: begin
        state_d     = e_freeze;
        core_cnt_d  = '0;
        instr_cnt_d = '0;
      end
      e_freeze: begin
        if (hs) state_d = e_core_id;
      end
      e_core_id: begin
        if (hs) state_d = e_rom_rd;
      end
      e_rom_rd: begin
        state_d = e_ucode;
      end
      e_ucode: begin
        if (hs) begin
          if (!instr_last) begin
            instr_cnt_d = instr_cnt_q + 1'b1;
            state_d     = e_rom_rd;
          end else begin
            instr_cnt_d = '0;
            if (!core_last) begin
              core_cnt_d = core_cnt_q + 1'b1;
              state_d    = e_freeze;
            end else begin
              core_cnt_d = '0;
              state_d    = e_unfreeze;
            end
          end
        end
      end
      e_unfreeze: begin
        if (hs) begin
          if (!core_last) begin
            core_cnt_d = core_cnt_q + 1'b1;
          end else begin
            core_cnt_d = '0;
            state_d    = e_done;
          end
        end
      end
      e_done: ;
      default: state_d = e_reset;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= e_reset;
      core_cnt_q    <= '0;
      instr_cnt_q   <= '0;
      word_q        <= '0;
      ucode_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      core_cnt_q    <= core_cnt_d;
      instr_cnt_q   <= instr_cnt_d;
      word_q        <= word_d;
      ucode_first_q <= ucode_first_d;
    end
  end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Bench for bp_cfg_loader: a 2-core/4-entry and a 1-core/1-entry instance share clock, reset
// and ready; the expected write stream of the selected instance is checked from a queue.
module tb_bp_cfg_loader;

  typedef struct {
    logic [7:0]  core;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rdy;
  logic sel;

  logic [1:0]  rom_addr_a;
  logic [31:0] rom_data_a;
  logic        v_a, done_a;
  logic [7:0]  core_a;
  logic [15:0] addr_a;
  logic [31:0] data_a;

  logic [0:0]  rom_addr_b;
  logic [31:0] rom_data_b;
  logic        v_b, done_b;
  logic [7:0]  core_b;
  logic [15:0] addr_b;
  logic [31:0] data_b;

  bp_cfg_loader #(
    .num_core_p              (2),
    .num_cce_instr_ram_els_p (4),
    .cfg_core_width_p        (8),
    .cfg_addr_width_p        (16),
    .cfg_data_width_p        (32)
  ) u_dut_a (
    .clk_i       (clk),
    .reset_i     (rst),
    .rom_addr_o  (rom_addr_a),
    .rom_data_i  (rom_data_a),
    .cfg_v_o     (v_a),
    .cfg_core_o  (core_a),
    .cfg_addr_o  (addr_a),
    .cfg_data_o  (data_a),
    .cfg_ready_i (rdy),
    .done_o      (done_a)
  );

  bp_cfg_loader #(
    .num_core_p              (1),
    .num_cce_instr_ram_els_p (1),
    .cfg_core_width_p        (8),
    .cfg_addr_width_p        (16),
    .cfg_data_width_p        (32)
  ) u_dut_b (
    .clk_i       (clk),
    .reset_i     (rst),
    .rom_addr_o  (rom_addr_b),
    .rom_data_i  (rom_data_b),
    .cfg_v_o     (v_b),
    .cfg_core_o  (core_b),
    .cfg_addr_o  (addr_b),
    .cfg_data_o  (data_b),
    .cfg_ready_i (rdy),
    .done_o      (done_b)
  );

  // Synchronous ROMs: word valid the cycle after the address is presented.
  always @(posedge clk) begin
    rom_data_a <= 32'hA5A5_0000 | {30'd0, rom_addr_a};
    rom_data_b <= 32'hA5A5_0000 | {31'd0, rom_addr_b};
  end

  logic        obs_v, obs_done;
  logic [7:0]  obs_core, obs_rom;
  logic [15:0] obs_addr;
  logic [31:0] obs_data;

  assign obs_v    = sel ? v_b    : v_a;
  assign obs_done = sel ? done_b : done_a;
  assign obs_core = sel ? core_b : core_a;
  assign obs_addr = sel ? addr_b : addr_a;
  assign obs_data = sel ? data_b : data_a;
  assign obs_rom  = sel ? {7'd0, rom_addr_b} : {6'd0, rom_addr_a};

  int  n_vec;
  int  n_err;
  wr_t tbl_a[14];
  wr_t tbl_b[4];
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] payload();
    return {8'h00, obs_core, obs_addr, obs_data};
  endfunction

  task automatic load_q();
    exp_q.delete();
    if (sel) begin
      foreach (tbl_b[i]) exp_q.push_back(tbl_b[i]);
    end else begin
      foreach (tbl_a[i]) exp_q.push_back(tbl_a[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_v", 64'(obs_v), 64'd0);
    chk("rst_done", 64'(obs_done), 64'd0);
    chk("rst_payload", payload(), 64'd0);
    chk("rst_rom_addr", 64'(obs_rom), 64'd0);
    rst = 1'b0;
    load_q();
  endtask

  // mode 0: always ready, 1: random ready, 2: 5-cycle stall on c0 0x8002,
  // 3: reset pulse during c1 0x8001 then full rerun.
  task automatic run(input int mode);
    int          stall = 0;
    bit          did_rst = 1'b0;
    bit          pend = 1'b0;
    bit          fin = 1'b0;
    bit          ok = 1'b0;
    bit          r;
    logic [63:0] saved = '0;
    wr_t         e;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (fin) begin
        chk("done_rise", 64'(obs_done), 64'd1);
        chk("v_after_done", 64'(obs_v), 64'd0);
        ok = 1'b1;
        break;
      end
      if (pend) begin
        chk("hold_v", 64'(obs_v), 64'd1);
        chk("hold_payload", payload(), saved);
      end
      chk("done_low", 64'(obs_done), 64'd0);
      if (mode == 3 && !did_rst && obs_v && obs_core == 8'd1 && obs_addr == 16'h8001) begin
        did_rst = 1'b1;
        rst = 1'b1;
        rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_v", 64'(obs_v), 64'd0);
        chk("mid_rst_done", 64'(obs_done), 64'd0);
        chk("mid_rst_payload", payload(), 64'd0);
        load_q();
        pend = 1'b0;
        continue;
      end
      case (mode)
        1: r = 1'($urandom_range(0, 1));
        2: begin
          r = !(obs_v && obs_core == 8'd0 && obs_addr == 16'h8002 && stall < 5);
          if (!r) stall++;
        end
        default: r = 1'b1;
      endcase
      rdy = r;
      if (obs_v && r) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_write: got %h expected none", payload());
        end else begin
          e = exp_q.pop_front();
          chk("write", payload(), {8'h00, e.core, e.addr, e.data});
          if (exp_q.size() == 0) fin = 1'b1;
        end
      end
      pend  = obs_v && !r;
      saved = payload();
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got %0d writes outstanding expected 0", exp_q.size());
    end
    if (mode == 2) chk("stall_cycles", 64'(stall), 64'd5);
    if (mode == 3) chk("reset_pulsed", 64'(did_rst), 64'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    sel   = 1'b0;
    rst   = 1'b1;
    rdy   = 1'b0;

    tbl_a[0]  = '{8'd0, 16'h0000, 32'h0000_0001};
    tbl_a[1]  = '{8'd0, 16'h0001, 32'h0000_0000};
    tbl_a[2]  = '{8'd0, 16'h8000, 32'hA5A5_0000};
    tbl_a[3]  = '{8'd0, 16'h8001, 32'hA5A5_0001};
    tbl_a[4]  = '{8'd0, 16'h8002, 32'hA5A5_0002};
    tbl_a[5]  = '{8'd0, 16'h8003, 32'hA5A5_0003};
    tbl_a[6]  = '{8'd1, 16'h0000, 32'h0000_0001};
    tbl_a[7]  = '{8'd1, 16'h0001, 32'h0000_0001};
    tbl_a[8]  = '{8'd1, 16'h8000, 32'hA5A5_0000};
    tbl_a[9]  = '{8'd1, 16'h8001, 32'hA5A5_0001};
    tbl_a[10] = '{8'd1, 16'h8002, 32'hA5A5_0002};
    tbl_a[11] = '{8'd1, 16'h8003, 32'hA5A5_0003};
    tbl_a[12] = '{8'd0, 16'h0000, 32'h0000_0000};
    tbl_a[13] = '{8'd1, 16'h0000, 32'h0000_0000};

    tbl_b[0]  = '{8'd0, 16'h0000, 32'h0000_0001};
    tbl_b[1]  = '{8'd0, 16'h0001, 32'h0000_0000};
    tbl_b[2]  = '{8'd0, 16'h8000, 32'hA5A5_0000};
    tbl_b[3]  = '{8'd0, 16'h0000, 32'h0000_0000};

    do_reset();
    run(0);
    do_reset();
    run(1);
    do_reset();
    run(2);
    do_reset();
    run(3);
    sel = 1'b1;
    do_reset();
    run(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
